// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM: register-select codes and MODE bit positions.
package pwm_pkg;

   typedef enum logic [1:0] {
      SEL_PERIOD = 2'd0,
      SEL_DUTY   = 2'd1,
      SEL_MODE   = 2'd2,
      SEL_RSVD   = 2'd3
   } wr_sel_e;

   localparam int MODE_CENTRE = 0;
   localparam int MODE_INV    = 1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active period, duty and mode, an up or up/down counter,
// a registered output pin and a registered period-end strobe.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CW = 28
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  wr_sel_e       wr_sel,
   input  logic [CW-1:0] wr_data,
   input  logic          enable,
   output logic          pwm_out,
   output logic          period_end
);

   logic [CW-1:0] shd_period, shd_duty, act_period, act_duty;
   logic [1:0]    shd_mode, act_mode;
   logic [CW-1:0] cnt, last;
   logic          cnt_down;
   logic          centre, wrap, raw;

   // Centre mode with P=1 degenerates to the edge-mode single-cycle period.
   assign centre = act_mode[MODE_CENTRE] && (act_period > CW'(1));
   assign last   = act_period - CW'(1);
   assign raw    = cnt < act_duty;

   always_comb begin
      wrap = 1'b0;
      if (centre)
         wrap = cnt_down ? (cnt == CW'(1)) : ((cnt == last) && (act_period == CW'(2)));
      else
         wrap = (cnt == last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_period <= '0;
         shd_duty   <= '0;
         shd_mode   <= '0;
         act_period <= '0;
         act_duty   <= '0;
         act_mode   <= '0;
         cnt        <= '0;
         cnt_down   <= 1'b0;
         pwm_out    <= 1'b0;
         period_end <= 1'b0;
      end else begin
         if (wr_en) begin
            case (wr_sel)
               SEL_PERIOD: shd_period <= wr_data;
               SEL_DUTY:   shd_duty   <= wr_data;
               SEL_MODE:   shd_mode   <= wr_data[1:0];
               default:    ;
            endcase
         end
         // Disabled or zero-period channels sit at CNT=0 and track the shadow registers.
         if (!enable || (act_period == '0)) begin
            cnt        <= '0;
            cnt_down   <= 1'b0;
            act_period <= shd_period;
            act_duty   <= shd_duty;
            act_mode   <= shd_mode;
            period_end <= 1'b0;
            pwm_out    <= enable ? act_mode[MODE_INV] : shd_mode[MODE_INV];
         end else begin
            pwm_out    <= raw ^ act_mode[MODE_INV];
            period_end <= wrap;
            if (wrap) begin
               cnt        <= '0;
               cnt_down   <= 1'b0;
               act_period <= shd_period;
               act_duty   <= shd_duty;
               act_mode   <= shd_mode;
            end else if (centre && !cnt_down && (cnt == last)) begin
               cnt      <= cnt - CW'(1);
               cnt_down <= 1'b1;
            end else if (cnt_down) begin
               cnt <= cnt - CW'(1);
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// N-channel PWM controller: decodes the shared register-write port into per-channel
// write strobes and instantiates one independent pwm_channel per output.
module pwm_multi_ctrl
   import pwm_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = 28,
   parameter int CHW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en,
   input  logic [CHW-1:0] wr_ch,
   input  logic [1:0]     wr_sel,
   input  logic [CW-1:0]  wr_data,
   input  logic [NCH-1:0] enable,
   output logic [NCH-1:0] pwm_out,
   output logic [NCH-1:0] period_end
);

   logic [NCH-1:0] ch_we;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         // Reserved select and out-of-range channel indices never produce a strobe.
         assign ch_we[gi] = wr_en && (wr_ch == CHW'(gi)) && (wr_sel != SEL_RSVD);

         pwm_channel #(.CW(CW)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (ch_we[gi]),
            .wr_sel     (wr_sel_e'(wr_sel)),
            .wr_data    (wr_data),
            .enable     (enable[gi]),
            .pwm_out    (pwm_out[gi]),
            .period_end (period_end[gi])
         );
      end
   endgenerate

endmodule
